// File: rtl/ssb_re_extractor.sv
// SSB resource-element extractor: windows the fftshifted bin stream of SSB symbols 1-3
// and forwards PBCH/SSS REs as one tagged stream with a per-symbol tlast.
module ssb_re_extractor #(
  parameter int IN_DW = 32,
  parameter int NFFT  = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [IN_DW-1:0] s_axis_in_tdata,
  input  logic             s_axis_in_tvalid,
  input  logic             PBCH_valid_i,
  input  logic             SSS_valid_i,
  output logic [IN_DW-1:0] m_axis_out_tdata,
  output logic [10:0]      m_axis_out_tuser,
  output logic             m_axis_out_tlast,
  output logic             m_axis_out_tvalid,
  output logic             symbol_error_o
);

  localparam int FFT_LEN   = 2**NFFT;
  localparam int WIN_START = FFT_LEN/2 - 120;
  localparam logic [NFFT-1:0] WIN_LO  = NFFT'(WIN_START);
  localparam logic [NFFT-1:0] WIN_HI  = NFFT'(WIN_START + 239);
  localparam logic [NFFT-1:0] BIN_MAX = NFFT'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SYM1 = 2'd1, SYM2 = 2'd2, SYM3 = 2'd3} state_t;
  typedef enum logic [1:0] {PREV_NONE = 2'd0, PREV_SYM1 = 2'd1, PREV_SYM2 = 2'd2} prev_t;

  state_t          r_state, w_state_nxt, w_sym;
  prev_t           r_prev, w_prev_nxt;
  logic [NFFT-1:0] r_bin, w_bin_nxt;
  logic            w_err, w_bin_ok;
  logic            w_in_win, w_sss_k, w_pbch2_k, w_is_sss, w_sel;
  logic [7:0]      w_k;

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_bin_nxt   = r_bin;
    w_sym       = r_state;
    w_err       = 1'b0;
    w_bin_ok    = 1'b0;
    if (s_axis_in_tvalid) begin
      if (SSS_valid_i && !PBCH_valid_i) begin
        w_err = 1'b1;
      end else if (r_state == IDLE) begin
        if (PBCH_valid_i) begin
          w_bin_ok = 1'b1;
          if (SSS_valid_i)              w_sym = SYM2;
          else if (r_prev == PREV_SYM2) w_sym = SYM3;
          else                          w_sym = SYM1;
        end
      end else if (!PBCH_valid_i || (SSS_valid_i != (r_state == SYM2))) begin
        w_err = 1'b1;
      end else begin
        w_bin_ok = 1'b1;
      end

      if (w_err) begin
        w_state_nxt = IDLE;
        w_prev_nxt  = PREV_NONE;
        w_bin_nxt   = '0;
      end else if (w_bin_ok) begin
        w_bin_nxt = r_bin + NFFT'(1);
        if (r_bin == BIN_MAX) begin
          w_state_nxt = IDLE;
          case (w_sym)
            SYM1:    w_prev_nxt = PREV_SYM1;
            SYM2:    w_prev_nxt = PREV_SYM2;
            default: w_prev_nxt = PREV_NONE;
          endcase
        end else begin
          w_state_nxt = w_sym;
        end
      end
    end
  end

  // Window selection for the bin being accepted this cycle (w_sym already names its symbol)
  always_comb begin
    w_in_win  = (r_bin >= WIN_LO) && (r_bin <= WIN_HI);
    w_k       = 8'(r_bin - WIN_LO);
    w_sss_k   = (w_k >= 8'd56) && (w_k <= 8'd182);
    w_pbch2_k = (w_k <= 8'd47) || (w_k >= 8'd192);
    w_is_sss  = (w_sym == SYM2) && w_sss_k;
    w_sel     = w_bin_ok && w_in_win && ((w_sym != SYM2) || w_sss_k || w_pbch2_k);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state           <= IDLE;
      r_prev            <= PREV_NONE;
      r_bin             <= '0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tuser  <= '0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      symbol_error_o    <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_prev            <= w_prev_nxt;
      r_bin             <= w_bin_nxt;
      m_axis_out_tvalid <= w_sel;
      m_axis_out_tlast  <= w_sel && (w_k == 8'd239);
      symbol_error_o    <= w_err;
      if (w_sel) begin
        m_axis_out_tdata <= s_axis_in_tdata;
        m_axis_out_tuser <= {w_is_sss, 2'(w_sym), w_k};
      end
    end
  end

endmodule

// File: tb/tb_ssb_re_extractor.sv
// Self-checking bench for ssb_re_extractor: NFFT=8 and NFFT=9 instances, directed
// scenarios plus a randomized symbol sequence checked against a symbol-level model.
module tb_ssb_re_extractor;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sel, v, p, s;
  logic [DW-1:0] d;
  logic [DW-1:0] td8, td9;
  logic [10:0]   tu8, tu9;
  logic          tl8, tl9, tv8, tv9, er8, er9;

  ssb_re_extractor #(.IN_DW(DW), .NFFT(8)) u_dut8 (
    .clk_i(clk), .reset_ni(rst_n), .s_axis_in_tdata(d),
    .s_axis_in_tvalid(v & ~sel), .PBCH_valid_i(p & ~sel), .SSS_valid_i(s & ~sel),
    .m_axis_out_tdata(td8), .m_axis_out_tuser(tu8), .m_axis_out_tlast(tl8),
    .m_axis_out_tvalid(tv8), .symbol_error_o(er8));

  ssb_re_extractor #(.IN_DW(DW), .NFFT(9)) u_dut9 (
    .clk_i(clk), .reset_ni(rst_n), .s_axis_in_tdata(d),
    .s_axis_in_tvalid(v & sel), .PBCH_valid_i(p & sel), .SSS_valid_i(s & sel),
    .m_axis_out_tdata(td9), .m_axis_out_tuser(tu9), .m_axis_out_tlast(tl9),
    .m_axis_out_tvalid(tv9), .symbol_error_o(er9));

  logic [DW-1:0] o_d;
  logic [10:0]   o_u;
  logic          o_l, o_v, o_e;
  assign o_d = sel ? td9 : td8;
  assign o_u = sel ? tu9 : tu8;
  assign o_l = sel ? tl9 : tl8;
  assign o_v = sel ? tv9 : tv8;
  assign o_e = sel ? er9 : er8;

  int n_pass = 0;
  int n_total = 0;
  int prev_m[2];             // model: previous completed symbol (0 none, 1, 2) per instance
  logic [DW-1:0] darr[512];

  bit            cap_en;
  int            cap_n, cap_sss, cap_last;
  logic [10:0]   first_u;
  logic [DW-1:0] first_d, last_d, first_sss_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cap_clear();
    cap_n = 0; cap_sss = 0; cap_last = 0;
    first_u = '0; first_d = '0; last_d = '0; first_sss_d = '0;
  endtask

  // One clock: drive inputs, then check the registered response 1 ns after the edge
  task automatic cyc(input logic iv, input logic ip, input logic is, input logic [DW-1:0] id,
                     input logic irst, input logic ev, input logic [DW-1:0] ed,
                     input logic [10:0] eu, input logic el, input logic ee, input logic full);
    v = iv; p = ip; s = is; d = id; rst_n = irst;
    @(posedge clk);
    #1;
    chk("tvalid", {63'd0, o_v}, {63'd0, ev});
    chk("symbol_error", {63'd0, o_e}, {63'd0, ee});
    if (ev || full) begin
      chk("tdata", {32'd0, o_d}, {32'd0, ed});
      chk("tuser", {53'd0, o_u}, {53'd0, eu});
      chk("tlast", {63'd0, o_l}, {63'd0, el});
    end
    if (cap_en && o_v) begin
      if (cap_n == 0) begin first_u = o_u; first_d = o_d; end
      cap_n++;
      if (o_u[10]) begin
        if (cap_sss == 0) first_sss_d = o_d;
        cap_sss++;
      end
      if (o_l) cap_last++;
      last_d = o_d;
    end
  endtask

  // ek: 0 none, 1 qualifiers drop, 2 SSS level change, 3 SSS without PBCH, 4 reset pulse
  // dmode: 0 random data, 1 data = bin index, 2 data from darr
  task automatic send_sym(input bit sss, input int ek, input int eb, input bit gaps, input int dmode);
    int L, off, sym, k, ng;
    logic ev, et, el;
    logic [DW-1:0] dd;
    L   = sel ? 512 : 256;
    off = L/2 - 120;
    sym = sss ? 2 : ((prev_m[sel] == 2) ? 3 : 1);
    for (int b = 0; b < L; b++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        ng = $urandom_range(1, 5);
        for (int g = 0; g < ng; g++) cyc(1'b0, 1'b1, sss, $urandom, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      end
      dd = (dmode == 1) ? DW'(b) : ((dmode == 2) ? darr[b] : $urandom);
      if (ek != 0 && b == eb) begin
        case (ek)
          1: cyc(1'b1, 1'b0, 1'b0, dd, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
          2: cyc(1'b1, 1'b1, ~sss, dd, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
          3: cyc(1'b1, 1'b0, 1'b1, dd, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
          default: begin
            cyc(1'b1, 1'b1, sss, dd, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            prev_m[0] = 0; prev_m[1] = 0;
          end
        endcase
        prev_m[sel] = 0;
        return;
      end
      k  = b - off;
      ev = (k >= 0) && (k < 240);
      et = (sym == 2) && (k >= 56) && (k <= 182);
      if (sym == 2) ev = ev && ((k <= 47) || (k >= 192) || et);
      el = ev && (k == 239);
      cyc(1'b1, 1'b1, sss, dd, 1'b1, ev, dd, {et, 2'(sym), 8'(k)}, el, 1'b0, 1'b0);
    end
    prev_m[sel] = (sym == 3) ? 0 : sym;
  endtask

  initial begin
    int act, kind, eb, L;
    prev_m[0] = 0; prev_m[1] = 0;
    cap_en = 1'b0; cap_clear();
    sel = 1'b0; v = 1'b0; p = 1'b0; s = 1'b0; d = '0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // NFFT=8 PBCH-only symbol, tdata = bin index
    cap_clear(); cap_en = 1'b1;
    send_sym(1'b0, 0, 0, 1'b0, 1);
    cap_en = 1'b0;
    chk("n8_count", 64'(cap_n), 64'd240);
    chk("n8_first_data", {32'd0, first_d}, 64'd8);
    chk("n8_last_data", {32'd0, last_d}, 64'd247);
    chk("n8_tlast_count", 64'(cap_last), 64'd1);
    chk("n8_first_tuser", {53'd0, first_u}, {53'd0, 1'b0, 2'd1, 8'd0});

    // NFFT=9 full SSB back to back, gap-free then with gaps in symbol 2
    sel = 1'b1;
    for (int i = 0; i < 512; i++) darr[i] = $urandom;
    for (int r = 0; r < 2; r++) begin
      cap_clear(); cap_en = 1'b1;
      send_sym(1'b0, 0, 0, 1'b0, 2);
      cap_en = 1'b0;
      chk("ssb_sym1_count", 64'(cap_n), 64'd240);
      chk("ssb_sym1_tag", {62'd0, first_u[9:8]}, 64'd1);
      cap_clear(); cap_en = 1'b1;
      send_sym(1'b1, 0, 0, r == 1, 2);
      cap_en = 1'b0;
      chk("ssb_sym2_count", 64'(cap_n), 64'd223);
      chk("ssb_sym2_sss", 64'(cap_sss), 64'd127);
      chk("ssb_sym2_tag", {62'd0, first_u[9:8]}, 64'd2);
      chk("ssb_sym2_first_sss_bin", {32'd0, first_sss_d}, {32'd0, darr[192]});
      chk("ssb_sym2_tlast", 64'(cap_last), 64'd1);
      cap_clear(); cap_en = 1'b1;
      send_sym(1'b0, 0, 0, 1'b0, 2);
      cap_en = 1'b0;
      chk("ssb_sym3_count", 64'(cap_n), 64'd240);
      chk("ssb_sym3_tag", {62'd0, first_u[9:8]}, 64'd3);
    end

    // NFFT=8 qualifier drop at bin 100, then a fresh PBCH symbol
    sel = 1'b0;
    cap_clear(); cap_en = 1'b1;
    send_sym(1'b0, 1, 100, 1'b0, 1);
    cap_en = 1'b0;
    chk("drop_count", 64'(cap_n), 64'd92);
    chk("drop_no_tlast", 64'(cap_last), 64'd0);
    cap_clear(); cap_en = 1'b1;
    send_sym(1'b0, 0, 0, 1'b0, 0);
    cap_en = 1'b0;
    chk("after_drop_tag", {62'd0, first_u[9:8]}, 64'd1);

    // SSS without PBCH from idle, and SSS level changes inside symbols
    sel = 1'b1;
    cap_clear(); cap_en = 1'b1;
    send_sym(1'b1, 3, 0, 1'b0, 0);
    cap_en = 1'b0;
    chk("sss_only_count", 64'(cap_n), 64'd0);
    send_sym(1'b0, 2, 200, 1'b0, 0);
    send_sym(1'b0, 0, 0, 1'b0, 0);
    send_sym(1'b1, 2, 300, 1'b0, 0);
    send_sym(1'b0, 0, 0, 1'b0, 0);

    // Reset pulse at bin 50 of symbol 2, then a PBCH symbol must be tagged 1
    send_sym(1'b1, 4, 50, 1'b0, 0);
    cap_clear(); cap_en = 1'b1;
    send_sym(1'b0, 0, 0, 1'b0, 0);
    cap_en = 1'b0;
    chk("after_reset_tag", {62'd0, first_u[9:8]}, 64'd1);

    // Randomized symbol sequence across both instances
    for (int it = 0; it < 30; it++) begin
      sel = 1'($urandom_range(0, 1));
      L   = sel ? 512 : 256;
      act = $urandom_range(0, 9);
      if (act < 7) begin
        send_sym(1'($urandom_range(0, 2) == 0), 0, 0, 1'($urandom_range(0, 1)), 0);
      end else begin
        kind = $urandom_range(1, 4);
        eb   = (kind <= 2) ? $urandom_range(1, L - 2) : $urandom_range(0, L - 1);
        send_sym(1'($urandom_range(0, 1)), kind, eb, 1'($urandom_range(0, 1)), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
